// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: forward-select encoding, default
// geometry and the packed layout of one scoreboard slot {valid, wreg, m2reg, dest}.
package hazard_scoreboard_pkg;

    localparam int FORWARD_NONE     = 0;
    localparam int DEF_REG_ADDR_W   = 5;
    localparam int DEF_STAGES       = 3;
    localparam int DEF_LOAD_LATENCY = 2;

    // Flag bits sit directly above the destination field, valid at the top.
    localparam int SLOT_FLAG_W    = 3;
    localparam int SLOT_VALID_OFS = 2;
    localparam int SLOT_WREG_OFS  = 1;
    localparam int SLOT_M2REG_OFS = 0;

    function automatic int slot_width(input int addr_w);
        return addr_w + SLOT_FLAG_W;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_source_check.sv
// Youngest-match resolution for one ID source operand: yields a load-use stall
// request or the stage index whose result must be forwarded (0 = register file).
module hazard_source_check
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int STAGES       = DEF_STAGES,
    parameter int LOAD_LATENCY = DEF_LOAD_LATENCY,
    parameter int SEL_W        = $clog2(STAGES + 1)
) (
    input  logic [REG_ADDR_W-1:0]        i_src,
    input  logic                         i_uses,
    input  logic [STAGES-1:0]            i_slot_valid,
    input  logic [STAGES-1:0]            i_slot_wreg,
    input  logic [STAGES-1:0]            i_slot_m2reg,
    input  logic [STAGES*REG_ADDR_W-1:0] i_slot_dest,
    output logic                         o_stall,
    output logic [SEL_W-1:0]             o_sel
);

    logic             w_match_stall;
    logic [SEL_W-1:0] w_match_sel;

    // Walk oldest to youngest so the youngest matching slot overrides older ones.
    always_comb begin
        w_match_stall = 1'b0;
        w_match_sel   = SEL_W'(FORWARD_NONE);
        for (int k = STAGES; k >= 1; k--) begin
            if (i_uses && (i_src != {REG_ADDR_W{1'b0}}) && i_slot_valid[k-1] && i_slot_wreg[k-1]
                && (i_slot_dest[(k-1)*REG_ADDR_W +: REG_ADDR_W] == i_src)) begin
                w_match_stall = i_slot_m2reg[k-1] && (k < LOAD_LATENCY);
                w_match_sel   = SEL_W'(k);
            end else begin
                w_match_stall = w_match_stall;
                w_match_sel   = w_match_sel;
            end
        end
    end

    assign o_stall = w_match_stall;
    assign o_sel   = w_match_stall ? SEL_W'(FORWARD_NONE) : w_match_sel;

endmodule

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destinations with stall/forward decode for ID.
// Optional build macro HAZARD_SCOREBOARD_PERF_EN adds saturating stall/forward counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter  int STAGES       = DEF_STAGES,
    parameter  int LOAD_LATENCY = DEF_LOAD_LATENCY,
    localparam int SEL_W        = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic                  idUsesRs,
    input  logic                  idUsesRt,
    input  logic                  idWriteRegister,
    input  logic                  idMemToRegister,
    input  logic [REG_ADDR_W-1:0] idDest,
    input  logic                  flush,
    input  logic                  hold,
    output logic                  shouldStall,
    output logic [SEL_W-1:0]      forwardRs,
    output logic [SEL_W-1:0]      forwardRt
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]           stallCount,
    output logic [31:0]           forwardCount
`endif
);

    localparam int SLOT_W = slot_width(REG_ADDR_W);

    logic [SLOT_W-1:0]            r_slot [1:STAGES];
    logic [STAGES-1:0]            w_valid;
    logic [STAGES-1:0]            w_wreg;
    logic [STAGES-1:0]            w_m2reg;
    logic [STAGES*REG_ADDR_W-1:0] w_dest;
    logic                         w_rs_stall;
    logic                         w_rt_stall;
    logic                         w_should_stall;
    logic [SLOT_W-1:0]            w_id_slot;

    // Split the packed slots into per-field vectors for the source checkers.
    always_comb begin
        w_valid = '0;
        w_wreg  = '0;
        w_m2reg = '0;
        w_dest  = '0;
        for (int k = 1; k <= STAGES; k++) begin
            w_valid[k-1] = r_slot[k][REG_ADDR_W + SLOT_VALID_OFS];
            w_wreg[k-1]  = r_slot[k][REG_ADDR_W + SLOT_WREG_OFS];
            w_m2reg[k-1] = r_slot[k][REG_ADDR_W + SLOT_M2REG_OFS];
            w_dest[(k-1)*REG_ADDR_W +: REG_ADDR_W] = r_slot[k][REG_ADDR_W-1:0];
        end
    end

    hazard_source_check #(
        .REG_ADDR_W(REG_ADDR_W), .STAGES(STAGES), .LOAD_LATENCY(LOAD_LATENCY), .SEL_W(SEL_W)
    ) u_rs_check (
        .i_src(idRs), .i_uses(idUsesRs), .i_slot_valid(w_valid), .i_slot_wreg(w_wreg),
        .i_slot_m2reg(w_m2reg), .i_slot_dest(w_dest), .o_stall(w_rs_stall), .o_sel(forwardRs)
    );

    hazard_source_check #(
        .REG_ADDR_W(REG_ADDR_W), .STAGES(STAGES), .LOAD_LATENCY(LOAD_LATENCY), .SEL_W(SEL_W)
    ) u_rt_check (
        .i_src(idRt), .i_uses(idUsesRt), .i_slot_valid(w_valid), .i_slot_wreg(w_wreg),
        .i_slot_m2reg(w_m2reg), .i_slot_dest(w_dest), .o_stall(w_rt_stall), .o_sel(forwardRt)
    );

    // A flushed or stalled ID instruction enters the scoreboard as a bubble.
    assign w_should_stall = idValid && !flush && (w_rs_stall || w_rt_stall);
    assign shouldStall    = w_should_stall;
    assign w_id_slot      = {idValid && !flush && !w_should_stall, idWriteRegister,
                             idMemToRegister, idDest};

    // Advance the scoreboard one stage per non-hold cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= STAGES; k++) begin
                r_slot[k] <= '0;
            end
        end else if (!hold) begin
            for (int k = STAGES; k >= 2; k--) begin
                r_slot[k] <= r_slot[k-1];
            end
            r_slot[1] <= w_id_slot;
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_forward_count;

    // Saturating activity counters, counted only on cycles the pipeline advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count   <= 32'd0;
            r_forward_count <= 32'd0;
        end else if (!hold) begin
            if (w_should_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (idValid && !w_should_stall && ((forwardRs != '0) || (forwardRt != '0))
                && (r_forward_count != 32'hFFFF_FFFF)) begin
                r_forward_count <= r_forward_count + 32'd1;
            end
        end
    end

    assign stallCount   = r_stall_count;
    assign forwardCount = r_forward_count;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios followed by
// random traffic, all compared against a list-of-instructions reference model.
module tb_hazard_scoreboard;

    localparam int RW = 5;
    localparam int NS = 3;
    localparam int LL = 2;
    localparam int SW = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          idValid = 1'b0;
    logic [RW-1:0] idRs = '0;
    logic [RW-1:0] idRt = '0;
    logic          idUsesRs = 1'b0;
    logic          idUsesRt = 1'b0;
    logic          idWriteRegister = 1'b0;
    logic          idMemToRegister = 1'b0;
    logic [RW-1:0] idDest = '0;
    logic          flush = 1'b0;
    logic          hold = 1'b0;
    logic          shouldStall;
    logic [SW-1:0] forwardRs;
    logic [SW-1:0] forwardRt;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0]   stallCount;
    logic [31:0]   forwardCount;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: in-flight instructions, index 1 = youngest (just left ID).
    int m_valid [1:NS];
    int m_wreg  [1:NS];
    int m_load  [1:NS];
    int m_dest  [1:NS];
    int e_stall, e_frs, e_frt;
    int m_stall_cnt, m_fwd_cnt;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .idValid(idValid), .idRs(idRs), .idRt(idRt),
        .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idWriteRegister(idWriteRegister),
        .idMemToRegister(idMemToRegister), .idDest(idDest), .flush(flush), .hold(hold),
        .shouldStall(shouldStall), .forwardRs(forwardRs), .forwardRt(forwardRt)
`ifdef HAZARD_SCOREBOARD_PERF_EN
        , .stallCount(stallCount), .forwardCount(forwardCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 1; k <= NS; k++) begin
            m_valid[k] = 0; m_wreg[k] = 0; m_load[k] = 0; m_dest[k] = 0;
        end
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
    endtask

    // Search from the youngest in-flight instruction; the first writer found decides.
    task automatic resolve(input int src, input int uses, output int stall, output int sel);
        stall = 0;
        sel   = 0;
        if (uses != 0 && src != 0) begin
            for (int k = 1; k <= NS; k++) begin
                if (m_valid[k] != 0 && m_wreg[k] != 0 && m_dest[k] == src) begin
                    if (m_load[k] != 0 && k < LL) stall = 1;
                    else sel = k;
                    break;
                end
            end
        end
    endtask

    task automatic drive(input int v, input int rs, input int rt, input int urs, input int urt,
                         input int wr, input int ld, input int dst, input int fl, input int hd);
        idValid = 1'(v); idRs = RW'(rs); idRt = RW'(rt); idUsesRs = 1'(urs); idUsesRt = 1'(urt);
        idWriteRegister = 1'(wr); idMemToRegister = 1'(ld); idDest = RW'(dst);
        flush = 1'(fl); hold = 1'(hd);
    endtask

    task automatic eval(input string tag);
        int srs, srt;
        #2;
        resolve(int'(idRs), int'(idUsesRs), srs, e_frs);
        resolve(int'(idRt), int'(idUsesRt), srt, e_frt);
        e_stall = (idValid && !flush && (srs != 0 || srt != 0)) ? 1 : 0;
        chk({tag, ".stall"}, 32'(shouldStall), 32'(e_stall));
        chk({tag, ".fwdRs"}, 32'(forwardRs), 32'(e_frs));
        chk({tag, ".fwdRt"}, 32'(forwardRt), 32'(e_frt));
`ifdef HAZARD_SCOREBOARD_PERF_EN
        chk({tag, ".stallCnt"}, stallCount, 32'(m_stall_cnt));
        chk({tag, ".fwdCnt"}, forwardCount, 32'(m_fwd_cnt));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else if (!hold) begin
            if (e_stall != 0) m_stall_cnt++;
            else if (idValid && (e_frs != 0 || e_frt != 0)) m_fwd_cnt++;
            for (int k = NS; k >= 2; k--) begin
                m_valid[k] = m_valid[k-1]; m_wreg[k] = m_wreg[k-1];
                m_load[k]  = m_load[k-1];  m_dest[k] = m_dest[k-1];
            end
            m_valid[1] = (idValid && !flush && e_stall == 0) ? 1 : 0;
            m_wreg[1]  = int'(idWriteRegister);
            m_load[1]  = int'(idMemToRegister);
            m_dest[1]  = int'(idDest);
        end
        #1;
    endtask

    initial begin
        int h_stall, h_frs, h_frt;
        model_clear();
        e_stall = 0;
        drive(1, 3, 3, 1, 1, 1, 0, 3, 0, 0);
        #3;
        chk("reset.stall", 32'(shouldStall), 32'd0);
        chk("reset.fwdRs", 32'(forwardRs), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // add r3,r1,r2 ; add r4,r3,r5 ; reader of r3
        drive(1, 1, 2, 1, 1, 1, 0, 3, 0, 0); eval("add1"); tick();
        drive(1, 3, 5, 1, 1, 1, 0, 4, 0, 0); eval("add2");
        chk("tp_fwd_ex", 32'(forwardRs), 32'd1); tick();
        drive(1, 3, 0, 1, 0, 1, 0, 9, 0, 0); eval("add3");
        chk("tp_fwd_mem", 32'(forwardRs), 32'd2); tick();

        // lw r5,0(r1) ; add r6,r5,r7 -> one stall cycle then forward from stage 2
        drive(1, 1, 0, 1, 0, 1, 1, 5, 0, 0); eval("lw"); tick();
        drive(1, 5, 7, 1, 1, 1, 0, 6, 0, 0); eval("lu1");
        chk("tp_loaduse_stall", 32'(shouldStall), 32'd1); tick();
        eval("lu2");
        chk("tp_loaduse_release", 32'(shouldStall), 32'd0);
        chk("tp_loaduse_fwd", 32'(forwardRs), 32'd2); tick();

        // writer of r0 followed by reader of r0
        drive(1, 1, 1, 1, 1, 1, 1, 0, 0, 0); eval("r0w"); tick();
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0); eval("r0r");
        chk("tp_r0_fwd", 32'(forwardRs), 32'd0); tick();

        // r8 written twice, youngest wins; then youngest is a load
        drive(1, 1, 1, 1, 1, 1, 0, 8, 0, 0); eval("r8a"); tick();
        drive(1, 1, 1, 1, 1, 1, 0, 8, 0, 0); eval("r8b"); tick();
        drive(1, 2, 8, 1, 1, 0, 0, 0, 0, 0); eval("r8r");
        chk("tp_youngest", 32'(forwardRt), 32'd1); tick();
        drive(1, 1, 1, 1, 1, 1, 0, 8, 0, 0); eval("r8c"); tick();
        drive(1, 1, 1, 1, 1, 1, 1, 8, 0, 0); eval("r8ld"); tick();
        drive(1, 2, 8, 1, 1, 0, 0, 0, 0, 0); eval("r8lr");
        chk("tp_youngest_load", 32'(shouldStall), 32'd1); tick();

        // load-use concurrent with flush: no stall, bubble enters slot 1
        drive(1, 1, 1, 1, 1, 1, 1, 9, 0, 0); eval("fl_ld"); tick();
        drive(1, 1, 9, 1, 1, 1, 0, 10, 1, 0); eval("fl_use");
        chk("tp_flush_stall", 32'(shouldStall), 32'd0); tick();
        drive(1, 10, 9, 1, 1, 0, 0, 0, 0, 0); eval("fl_after");
        chk("tp_flush_bubble", 32'(forwardRs), 32'd0);
        chk("tp_flush_fwd", 32'(forwardRt), 32'd2); tick();

        // hold for three cycles with a pending load-use: nothing moves
        drive(1, 1, 1, 1, 1, 1, 0, 11, 0, 0); eval("h_w"); tick();
        drive(1, 1, 1, 1, 1, 1, 1, 12, 0, 0); eval("h_ld"); tick();
        drive(1, 12, 11, 1, 1, 0, 0, 0, 1, 1); eval("h0");
        drive(1, 12, 11, 1, 1, 0, 0, 0, 0, 1); eval("h0b");
        h_stall = e_stall; h_frs = e_frs; h_frt = e_frt;
        for (int i = 0; i < 3; i++) begin
            tick(); eval("hold");
            chk("tp_hold_stall", 32'(shouldStall), 32'(h_stall));
            chk("tp_hold_fwdRt", 32'(forwardRt), 32'(h_frt));
        end
        drive(1, 12, 11, 1, 1, 0, 0, 0, 0, 0); eval("h_rel"); tick();

        // reset with full scoreboard: outputs drop at once
        for (int i = 0; i < NS; i++) begin
            drive(1, 0, 0, 0, 0, 1, 0, 13, 0, 0); eval("fill"); tick();
        end
        drive(1, 13, 13, 1, 1, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("tp_rst_stall", 32'(shouldStall), 32'd0);
        chk("tp_rst_fwdRs", 32'(forwardRs), 32'd0);
        chk("tp_rst_fwdRt", 32'(forwardRt), 32'd0);
        tick();
        rst_n = 1'b1;
        eval("post_rst");
        chk("tp_post_rst", 32'(forwardRs), 32'd0); tick();

        // random traffic over a small register window to force frequent hazards
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) != 0) ? 1 : 0, $urandom_range(0, 5), $urandom_range(0, 5),
                  $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? 1 : 0,
                  $urandom_range(0, 1), $urandom_range(0, 5),
                  ($urandom_range(0, 9) == 0) ? 1 : 0, ($urandom_range(0, 6) == 0) ? 1 : 0);
            eval("rand");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
